// File: rtl/obi_arb_pkg.sv
// obi_arb_pkg
//   Shared definitions for the OBI memory arbiter.
//   - clog2_min1: ceil(log2(n)), never less than 1, so index and pointer
//     vectors stay at least one bit wide when n == 1.
//   - obi_req_t / obi_rsp_t: address- and response-phase bundles at the
//     default 32-bit address/data widths. They are meant for integrators
//     who wire the arbiter into structured interconnect.
package obi_arb_pkg;

   localparam int OBI_ADDR_WIDTH = 32;
   localparam int OBI_DATA_WIDTH = 32;

   function automatic int clog2_min1(input int value);
      int r;
      r = $clog2(value);
      return (r == 0) ? 1 : r;
   endfunction

   typedef struct packed {
      logic [OBI_ADDR_WIDTH-1:0]   addr;
      logic                        we;
      logic [OBI_DATA_WIDTH/8-1:0] be;
      logic [OBI_DATA_WIDTH-1:0]   wdata;
   } obi_req_t;

   typedef struct packed {
      logic [OBI_DATA_WIDTH-1:0] rdata;
      logic                      err;
   } obi_rsp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// obi_arb_id_fifo
//   Synchronous FIFO holding the port index of each granted transaction.
//   Responses return in order, so the head always names the port that
//   owns the next rvalid. The head is read combinationally, which keeps
//   the response path free of added latency.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset (empties FIFO)
//   push_i, data_i   write one index (ignored when full)
//   pop_i            drop the head entry (ignored when empty)
//   data_o           current head entry
//   full_o, empty_o  occupancy flags
module obi_arb_id_fifo
   import obi_arb_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_idx_reg;
   logic [PW-1:0]    rd_idx_reg;
   logic             wr_wrap_reg;
   logic             rd_wrap_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Equal indices: the wrap bits tell full from empty.
   assign full_o  = (wr_idx_reg == rd_idx_reg) & (wr_wrap_reg != rd_wrap_reg);
   assign empty_o = (wr_idx_reg == rd_idx_reg) & (wr_wrap_reg == rd_wrap_reg);
   assign data_o  = mem[rd_idx_reg];

   // Indices wrap explicitly at DEPTH-1 so that DEPTH == 1 also works.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_idx_reg  <= '0;
         rd_idx_reg  <= '0;
         wr_wrap_reg <= 1'b0;
         rd_wrap_reg <= 1'b0;
      end else begin
         if (do_push) begin
            if (wr_idx_reg == PW'(DEPTH-1)) begin
               wr_idx_reg  <= '0;
               wr_wrap_reg <= ~wr_wrap_reg;
            end else begin
               wr_idx_reg <= wr_idx_reg + 1'b1;
            end
         end
         if (do_pop) begin
            if (rd_idx_reg == PW'(DEPTH-1)) begin
               rd_idx_reg  <= '0;
               rd_wrap_reg <= ~rd_wrap_reg;
            end else begin
               rd_idx_reg <= rd_idx_reg + 1'b1;
            end
         end
      end
   end

   // Storage needs no reset; the pointers define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_idx_reg] <= data_i;
      end
   end

endmodule

// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter
//   N-to-1 OBI arbiter. Round-robin selection with the address phase
//   locked while the subordinate withholds the grant. Granted port
//   indices are queued so that in-order responses go back to the right
//   manager. Both phases pass through with zero added latency.
//   Optional build macro OBI_ARB_PERF_EN adds stall_cnt_o: one 32-bit
//   saturating count per port of cycles with req_i set and gnt_o clear.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_i/gnt_o                  per-port address-phase handshake
//   addr_i/we_i/be_i/wdata_i     per-port request fields, port 0 in LSBs
//   rvalid_o, rdata_o, err_o     per-port response valid, shared data/error
//   mem_*                        downstream OBI subordinate interface
//   protocol_err_o               sticky: rvalid arrived with nothing outstanding
//   stall_cnt_o                  (OBI_ARB_PERF_EN only) per-port stall counters
module obi_mem_arbiter
   import obi_arb_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_PORTS-1:0]            req_i,
   output logic [NUM_PORTS-1:0]            gnt_o,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_PORTS-1:0]            we_i,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
   output logic [NUM_PORTS-1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0]           rdata_o,
   output logic                            err_o,
   output logic                            mem_req_o,
   input  logic                            mem_gnt_i,
   input  logic                            mem_rvalid_i,
   output logic [ADDR_WIDTH-1:0]           mem_addr_o,
   output logic                            mem_we_o,
   output logic [DATA_WIDTH/8-1:0]         mem_be_o,
   output logic [DATA_WIDTH-1:0]           mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]           mem_rdata_i,
   input  logic                            mem_err_i,
   output logic                            protocol_err_o
`ifdef OBI_ARB_PERF_EN
   ,
   output logic [NUM_PORTS*32-1:0]         stall_cnt_o
`endif
);

   localparam int IW = clog2_min1(NUM_PORTS);
   localparam int BW = DATA_WIDTH / 8;

   logic [IW-1:0]         rr_ptr_reg;
   logic [IW-1:0]         sel_reg;
   logic                  lock_reg;
   logic                  proto_err_reg;
   logic [IW-1:0]         rr_sel;
   logic [IW-1:0]         sel;
   logic [IW-1:0]         head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  handshake;
   logic                  rsp_valid;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
   logic [BW-1:0]         be_arr    [NUM_PORTS];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign be_arr[gi]    = be_i[gi*BW +: BW];
      assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   // First requesting port at or after rr_ptr, wrapping around.
   always_comb begin : rr_scan
      logic          found;
      logic [IW-1:0] idx;
      rr_sel = rr_ptr_reg;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = IW'((int'(rr_ptr_reg) + i) % NUM_PORTS);
         if (!found && req_i[idx]) begin
            rr_sel = idx;
            found  = 1'b1;
         end
      end
   end

   // A pending, ungranted request keeps its port on the bus.
   assign sel = lock_reg ? sel_reg : rr_sel;

   assign mem_req_o   = (|req_i) & ~fifo_full & ~rst_i;
   assign handshake   = mem_req_o & mem_gnt_i;
   assign mem_addr_o  = addr_arr[sel];
   assign mem_we_o    = we_i[sel];
   assign mem_be_o    = be_arr[sel];
   assign mem_wdata_o = wdata_arr[sel];

   assign rsp_valid = mem_rvalid_i & ~fifo_empty & ~rst_i;
   assign rdata_o   = mem_rdata_i;
   assign err_o     = mem_err_i;
   assign protocol_err_o = proto_err_reg;

   always_comb begin
      gnt_o    = '0;
      rvalid_o = '0;
      if (handshake) begin
         gnt_o[sel] = 1'b1;
      end
      if (rsp_valid) begin
         rvalid_o[head] = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_reg    <= '0;
         sel_reg       <= '0;
         lock_reg      <= 1'b0;
         proto_err_reg <= 1'b0;
      end else begin
         if (handshake) begin
            rr_ptr_reg <= (int'(sel) == NUM_PORTS - 1) ? '0 : sel + 1'b1;
            lock_reg   <= 1'b0;
         end else if (mem_req_o) begin
            lock_reg <= 1'b1;
            sel_reg  <= sel;
         end
         // A response with nothing outstanding is flagged even when a push
         // lands in the same cycle: that push belongs to a newer request.
         if (mem_rvalid_i && fifo_empty) begin
            proto_err_reg <= 1'b1;
         end
      end
   end

   obi_arb_id_fifo #(
      .WIDTH (IW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (handshake),
      .data_i  (sel),
      .pop_i   (rsp_valid),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef OBI_ARB_PERF_EN
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stall
      logic [31:0] cnt_reg;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            cnt_reg <= '0;
         end else if (req_i[gi] && !gnt_o[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
      assign stall_cnt_o[gi*32 +: 32] = cnt_reg;
   end
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter
//   Directed bench for obi_mem_arbiter with three ports and two outstanding
//   transactions. Inputs change 2 time units after a rising edge and outputs
//   are sampled 1 unit later, well clear of the next edge.
module tb_obi_mem_arbiter;

   localparam int NP = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MO = 2;

   localparam logic [AW-1:0] A0 = 32'h0000_1000;
   localparam logic [AW-1:0] A1 = 32'h0000_0100;
   localparam logic [AW-1:0] A2 = 32'h0000_3000;
   localparam logic [DW-1:0] W0 = 32'h1111_0000;
   localparam logic [DW-1:0] W1 = 32'h2222_0000;
   localparam logic [DW-1:0] W2 = 32'h3333_0000;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic [NP-1:0]     req_i = '0;
   logic [NP-1:0]     gnt_o;
   logic [NP*AW-1:0]  addr_i;
   logic [NP-1:0]     we_i;
   logic [NP*BW-1:0]  be_i;
   logic [NP*DW-1:0]  wdata_i;
   logic [NP-1:0]     rvalid_o;
   logic [DW-1:0]     rdata_o;
   logic              err_o;
   logic              mem_req_o;
   logic              mem_gnt_i = 1'b0;
   logic              mem_rvalid_i = 1'b0;
   logic [AW-1:0]     mem_addr_o;
   logic              mem_we_o;
   logic [BW-1:0]     mem_be_o;
   logic [DW-1:0]     mem_wdata_o;
   logic [DW-1:0]     mem_rdata_i = '0;
   logic              mem_err_i = 1'b0;
   logic              protocol_err_o;
`ifdef OBI_ARB_PERF_EN
   logic [NP*32-1:0]  stall_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   assign addr_i  = {A2, A1, A0};
   assign we_i    = 3'b101;
   assign be_i    = {4'hC, 4'h3, 4'hF};
   assign wdata_i = {W2, W1, W0};

   obi_mem_arbiter #(
      .NUM_PORTS       (NP),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_i          (req_i),
      .gnt_o          (gnt_o),
      .addr_i         (addr_i),
      .we_i           (we_i),
      .be_i           (be_i),
      .wdata_i        (wdata_i),
      .rvalid_o       (rvalid_o),
      .rdata_o        (rdata_o),
      .err_o          (err_o),
      .mem_req_o      (mem_req_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_addr_o     (mem_addr_o),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i),
      .mem_err_i      (mem_err_i),
      .protocol_err_o (protocol_err_o)
`ifdef OBI_ARB_PERF_EN
      ,
      .stall_cnt_o    (stall_cnt_o)
`endif
   );

   task automatic drive(input logic [NP-1:0] req, input logic gnt, input logic rvalid,
                        input logic [DW-1:0] rdata, input logic err);
      req_i        = req;
      mem_gnt_i    = gnt;
      mem_rvalid_i = rvalid;
      mem_rdata_i  = rdata;
      mem_err_i    = err;
   endtask

   task automatic next_cycle;
      @(posedge clk_i);
      #2;
   endtask

   task automatic do_reset;
      drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
      rst_i = 1'b1;
      #3;
      rst_i = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset;
      drive(3'b111, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
      #13;
      checks++; if (gnt_o !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=%b", gnt_o, 3'b000); end
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
      checks++; if (rvalid_o !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=%b", rvalid_o, 3'b000); end
      checks++; if (protocol_err_o !== 1'b0) begin failures++; $display("FAIL reset_proto got=%b exp=0", protocol_err_o); end
      @(posedge clk_i);
      #2;
      drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
      rst_i = 1'b0;
      #1;
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_idle_req got=%b exp=0", mem_req_o); end
      $display("txn reset done");
      next_cycle();
   endtask

   task automatic test_single;
      drive(3'b010, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (gnt_o !== 3'b010) begin failures++; $display("FAIL single_gnt got=%b exp=%b", gnt_o, 3'b010); end
      checks++; if (mem_addr_o !== A1) begin failures++; $display("FAIL single_addr got=%h exp=%h", mem_addr_o, A1); end
      checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL single_we got=%b exp=0", mem_we_o); end
      $display("txn single req port1 addr=%h", mem_addr_o);
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      #1;
      checks++; if (rvalid_o !== 3'b010) begin failures++; $display("FAIL single_rvalid got=%b exp=%b", rvalid_o, 3'b010); end
      checks++; if (rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata_o); end
      $display("txn single rsp rdata=%h", rdata_o);
      next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checks++; if (protocol_err_o !== 1'b0) begin failures++; $display("FAIL single_proto got=%b exp=0", protocol_err_o); end
      next_cycle();
   endtask

   task automatic test_fairness;
      logic [NP-1:0] exp_g [6];
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive(3'b111, 1'b1, (k > 0), 32'h0000_A000 + k, 1'b0);
         #1;
         checks++; if (gnt_o !== exp_g[k]) begin failures++; $display("FAIL fair_gnt%0d got=%b exp=%b", k, gnt_o, exp_g[k]); end
         if (k > 0) begin
            checks++; if (rvalid_o !== exp_g[k-1]) begin failures++; $display("FAIL fair_rvalid%0d got=%b exp=%b", k, rvalid_o, exp_g[k-1]); end
         end
         $display("txn fair cycle %0d gnt=%b rvalid=%b", k, gnt_o, rvalid_o);
         next_cycle();
      end
      drive(3'b000, 1'b0, 1'b1, 32'h0000_A006, 1'b0);
      #1;
      checks++; if (rvalid_o !== 3'b100) begin failures++; $display("FAIL fair_drain got=%b exp=%b", rvalid_o, 3'b100); end
      next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checks++; if (protocol_err_o !== 1'b0) begin failures++; $display("FAIL fair_proto got=%b exp=0", protocol_err_o); end
      next_cycle();
   endtask

   task automatic test_lock;
      // rr_ptr is 0 here. Port 2 alone stalls, then port 0 joins: port 2 must keep the bus.
      drive(3'b100, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checks++; if (mem_addr_o !== A2) begin failures++; $display("FAIL lockA_addr0 got=%h exp=%h", mem_addr_o, A2); end
      checks++; if (gnt_o !== 3'b000) begin failures++; $display("FAIL lockA_nognt got=%b exp=%b", gnt_o, 3'b000); end
      next_cycle();
      drive(3'b101, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checks++; if (mem_addr_o !== A2) begin failures++; $display("FAIL lockA_addr1 got=%h exp=%h", mem_addr_o, A2); end
      checks++; if (mem_be_o !== 4'hC) begin failures++; $display("FAIL lockA_be got=%h exp=c", mem_be_o); end
      next_cycle();
      drive(3'b101, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (gnt_o !== 3'b100) begin failures++; $display("FAIL lockA_gnt got=%b exp=%b", gnt_o, 3'b100); end
      $display("txn lockA gnt=%b", gnt_o);
      next_cycle();
      // Ports 0 and 2 request; three ungranted cycles keep port 0 on the bus.
      for (int k = 0; k < 3; k++) begin
         drive(3'b101, 1'b0, (k == 0), 32'h0000_0022, 1'b0);
         #1;
         checks++; if (mem_addr_o !== A0) begin failures++; $display("FAIL lockB_addr%0d got=%h exp=%h", k, mem_addr_o, A0); end
         if (k == 0) begin
            checks++; if (rvalid_o !== 3'b100) begin failures++; $display("FAIL lockB_rvalid got=%b exp=%b", rvalid_o, 3'b100); end
         end
         next_cycle();
      end
      drive(3'b101, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (gnt_o !== 3'b001) begin failures++; $display("FAIL lockB_gnt0 got=%b exp=%b", gnt_o, 3'b001); end
      next_cycle();
      drive(3'b101, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (gnt_o !== 3'b100) begin failures++; $display("FAIL lockB_gnt2 got=%b exp=%b", gnt_o, 3'b100); end
      checks++; if (mem_addr_o !== A2) begin failures++; $display("FAIL lockB_addr2 got=%h exp=%h", mem_addr_o, A2); end
      $display("txn lockB gnt=%b", gnt_o);
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 32'h0000_0033, 1'b0);
      #1;
      checks++; if (rvalid_o !== 3'b001) begin failures++; $display("FAIL lockB_rsp0 got=%b exp=%b", rvalid_o, 3'b001); end
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 32'h0000_0044, 1'b0);
      #1;
      checks++; if (rvalid_o !== 3'b100) begin failures++; $display("FAIL lockB_rsp2 got=%b exp=%b", rvalid_o, 3'b100); end
      next_cycle();
   endtask

   task automatic test_full;
      // rr_ptr is 0 and the FIFO is empty here.
      drive(3'b001, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (gnt_o !== 3'b001) begin failures++; $display("FAIL full_gnt0 got=%b exp=%b", gnt_o, 3'b001); end
      next_cycle();
      drive(3'b010, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (gnt_o !== 3'b010) begin failures++; $display("FAIL full_gnt1 got=%b exp=%b", gnt_o, 3'b010); end
      next_cycle();
      drive(3'b100, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL full_block_req got=%b exp=0", mem_req_o); end
      checks++; if (gnt_o !== 3'b000) begin failures++; $display("FAIL full_block_gnt got=%b exp=%b", gnt_o, 3'b000); end
      next_cycle();
      drive(3'b100, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1);
      #1;
      checks++; if (rvalid_o !== 3'b001) begin failures++; $display("FAIL full_rsp0 got=%b exp=%b", rvalid_o, 3'b001); end
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL full_err got=%b exp=1", err_o); end
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL full_still_req got=%b exp=0", mem_req_o); end
      next_cycle();
      drive(3'b100, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (gnt_o !== 3'b100) begin failures++; $display("FAIL full_reissue_gnt got=%b exp=%b", gnt_o, 3'b100); end
      checks++; if (mem_wdata_o !== W2) begin failures++; $display("FAIL full_wdata got=%h exp=%h", mem_wdata_o, W2); end
      checks++; if (mem_we_o !== 1'b1) begin failures++; $display("FAIL full_we got=%b exp=1", mem_we_o); end
      $display("txn full reissue gnt=%b", gnt_o);
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 32'h0000_0055, 1'b0);
      #1;
      checks++; if (rvalid_o !== 3'b010) begin failures++; $display("FAIL full_rsp1 got=%b exp=%b", rvalid_o, 3'b010); end
      next_cycle();
      drive(3'b000, 1'b0, 1'b1, 32'h0000_0066, 1'b0);
      #1;
      checks++; if (rvalid_o !== 3'b100) begin failures++; $display("FAIL full_rsp2 got=%b exp=%b", rvalid_o, 3'b100); end
      next_cycle();
   endtask

   task automatic test_stray;
      drive(3'b000, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0);
      #1;
      checks++; if (rvalid_o !== 3'b000) begin failures++; $display("FAIL stray_rvalid got=%b exp=%b", rvalid_o, 3'b000); end
      next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checks++; if (protocol_err_o !== 1'b1) begin failures++; $display("FAIL stray_proto got=%b exp=1", protocol_err_o); end
      next_cycle();
      #1;
      checks++; if (protocol_err_o !== 1'b1) begin failures++; $display("FAIL stray_sticky got=%b exp=1", protocol_err_o); end
      next_cycle();
      // Start a burst, then reset asynchronously in the middle of it.
      drive(3'b001, 1'b1, 1'b0, '0, 1'b0);
      #1;
      checks++; if (gnt_o !== 3'b001) begin failures++; $display("FAIL stray_burst_gnt got=%b exp=%b", gnt_o, 3'b001); end
      next_cycle();
      drive(3'b010, 1'b1, 1'b0, '0, 1'b0);
      #1;
      rst_i = 1'b1;
      #1;
      checks++; if (protocol_err_o !== 1'b0) begin failures++; $display("FAIL stray_async_clr got=%b exp=0", protocol_err_o); end
      checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL stray_rst_req got=%b exp=0", mem_req_o); end
      checks++; if (gnt_o !== 3'b000) begin failures++; $display("FAIL stray_rst_gnt got=%b exp=%b", gnt_o, 3'b000); end
      @(posedge clk_i);
      #2;
      drive(3'b000, 1'b0, 1'b1, 32'h0000_0077, 1'b0);
      rst_i = 1'b0;
      #1;
      checks++; if (rvalid_o !== 3'b000) begin failures++; $display("FAIL stray_discard got=%b exp=%b", rvalid_o, 3'b000); end
      next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checks++; if (protocol_err_o !== 1'b1) begin failures++; $display("FAIL stray_after_rst got=%b exp=1", protocol_err_o); end
      $display("txn stray proto=%b", protocol_err_o);
      next_cycle();
   endtask

`ifdef OBI_ARB_PERF_EN
   task automatic test_perf;
      do_reset();
      drive(3'b011, 1'b0, 1'b0, '0, 1'b0);
      repeat (5) next_cycle();
      drive(3'b000, 1'b0, 1'b0, '0, 1'b0);
      #1;
      checks++; if (stall_cnt_o[63:32] !== 32'd5) begin failures++; $display("FAIL perf_p1 got=%0d exp=5", stall_cnt_o[63:32]); end
      checks++; if (stall_cnt_o[31:0] !== 32'd5) begin failures++; $display("FAIL perf_p0 got=%0d exp=5", stall_cnt_o[31:0]); end
      checks++; if (stall_cnt_o[95:64] !== 32'd0) begin failures++; $display("FAIL perf_p2 got=%0d exp=0", stall_cnt_o[95:64]); end
      $display("txn perf p1=%0d", stall_cnt_o[63:32]);
      next_cycle();
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_lock();
      test_full();
      test_stray();
`ifdef OBI_ARB_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
